// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB bus bundle between a master and the register bank slave.
// Bit 0 is the MSB of every vector, matching OPB ordering.
interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus,
    output OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry,
    input  Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus,
    input  OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry,
    output Sl_toutSup, Sl_xferAck
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of 32-bit software registers feeding user logic.
// Define OPB_REG_BANK_SHADOW_EN for shadow registers with atomic commit.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01008200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010082FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_RESET_VAL  = 32'h00000000,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  opb_register_bank_ppc2simulink_if.slave opb,
  output logic [32*C_NUM_REGS-1:0]    user_data_out,
  output logic [C_NUM_REGS-1:0]       user_wr_stb
);

  typedef logic [C_NUM_REGS-1:0][31:0] bank_t;

  localparam int unused_cfg =
    C_OPB_AWIDTH + C_OPB_DWIDTH + $bits(C_FAMILY);

  logic [31:0] abus;
  logic [31:0] wdata;
  logic [31:0] offset;
  logic [31:0] idx;
  logic [31:0] rdata;
  logic        in_win;
  logic        hit;
  logic        take;
  logic        wr;
  logic        rd;

  logic                  ack_q, ack_d;
  logic                  lock_q, lock_d;
  logic [31:0]           dbus_q, dbus_d;
  logic [C_NUM_REGS-1:0] stb_q, stb_d;
  bank_t                 regs_q, regs_d;
`ifdef OPB_REG_BANK_SHADOW_EN
  bank_t                 shadow_q, shadow_d;
  logic [C_NUM_REGS-1:0] pend_q, pend_d;
`endif

  logic unused_bits;
  assign unused_bits = ^{opb.OPB_seqAddr, offset[1:0]};

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [0:3]  be
  );
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[31-8*k -: 8] = wd[31-8*k -: 8];
    end
    return r;
  endfunction

  assign abus   = opb.OPB_ABus;
  assign wdata  = opb.OPB_DBus;
  assign in_win = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign offset = abus - C_BASEADDR;
  assign idx    = {2'b00, offset[31:2]};
  assign hit    = opb.OPB_select & in_win;
  // lock_q keeps a select held past its ack from being taken twice
  assign take   = hit & ~ack_q & ~lock_q;
  assign wr     = take & ~opb.OPB_RNW;
  assign rd     = take & opb.OPB_RNW;

  always_comb begin
    regs_d = regs_q;
    stb_d  = '0;
    rdata  = '0;
`ifdef OPB_REG_BANK_SHADOW_EN
    shadow_d = shadow_q;
    pend_d   = pend_q;
`endif
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx == 32'(i)) begin
`ifdef OPB_REG_BANK_SHADOW_EN
        rdata = shadow_q[i];
        if (wr) begin
          shadow_d[i] = merge(shadow_q[i], wdata, opb.OPB_BE);
          pend_d[i]   = 1'b1;
        end
`else
        rdata = regs_q[i];
        if (wr) begin
          regs_d[i] = merge(regs_q[i], wdata, opb.OPB_BE);
          stb_d[i]  = 1'b1;
        end
`endif
      end
    end
`ifdef OPB_REG_BANK_SHADOW_EN
    if (idx == 32'(C_NUM_REGS)) begin
      rdata = 32'(pend_q);
      if (wr && wdata[0] && opb.OPB_BE[3]) begin
        regs_d = shadow_q;
        stb_d  = pend_q;
        pend_d = '0;
      end
    end
`endif
    ack_d  = take;
    lock_d = hit & (ack_q | lock_q);
    dbus_d = rd ? rdata : 32'h0;
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ack_q  <= 1'b0;
      lock_q <= 1'b0;
      dbus_q <= '0;
      stb_q  <= '0;
      regs_q <= {C_NUM_REGS{C_RESET_VAL}};
`ifdef OPB_REG_BANK_SHADOW_EN
      shadow_q <= {C_NUM_REGS{C_RESET_VAL}};
      pend_q   <= '0;
`endif
    end else begin
      ack_q  <= ack_d;
      lock_q <= lock_d;
      dbus_q <= dbus_d;
      stb_q  <= stb_d;
      regs_q <= regs_d;
`ifdef OPB_REG_BANK_SHADOW_EN
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
`endif
    end
  end

  assign opb.Sl_DBus    = dbus_q;
  assign opb.Sl_xferAck = ack_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;
  assign user_data_out  = regs_q;
  assign user_wr_stb    = stb_q;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for opb_register_bank_ppc2simulink.
// Shadow-mode vectors run when OPB_REG_BANK_SHADOW_EN is defined.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01008200;
  localparam logic [31:0] HIGH = 32'h010082FF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] udo;
  logic [3:0]   stb;

  int n_tests = 0;
  int n_fail  = 0;

  logic         ack_seen;
  logic [31:0]  rd_val;
  logic [31:0]  dbus_or;
  logic [3:0]   stb_at;
  logic [127:0] udo_at;
  logic         post_ack;
  logic [3:0]   post_stb;

  opb_register_bank_ppc2simulink_if bus ();

  opb_register_bank_ppc2simulink dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .opb           (bus),
    .user_data_out (udo),
    .user_wr_stb   (stb)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(
    input logic [31:0] addr,
    input logic        rnw,
    input logic [3:0]  be,
    input logic [31:0] data
  );
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = rnw;
    bus.OPB_BE     = be;
    bus.OPB_DBus   = data;
    bus.OPB_select = 1'b1;
    ack_seen = 1'b0;
    dbus_or  = '0;
    rd_val   = '0;
    stb_at   = '0;
    udo_at   = '0;
    for (int c = 0; c < 4 && !ack_seen; c++) begin
      tick();
      if (bus.Sl_xferAck) begin
        ack_seen = 1'b1;
        rd_val   = bus.Sl_DBus;
        stb_at   = stb;
        udo_at   = udo;
      end else begin
        dbus_or = dbus_or | bus.Sl_DBus;
      end
    end
    bus.OPB_select = 1'b0;
    bus.OPB_DBus   = '0;
    tick();
    post_ack = bus.Sl_xferAck;
    post_stb = stb;
  endtask

  initial begin
    int acks;
    int strobes;
    int ack_cyc;
    bus.OPB_ABus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_RNW     = 1'b1;
    bus.OPB_select  = 1'b0;
    bus.OPB_seqAddr = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_udo", udo, 128'h0);
    check("rst_stb", {124'h0, stb}, 128'h0);
    check("rst_ack", {127'h0, bus.Sl_xferAck}, 128'h0);
    check("rst_dbus", {96'h0, bus.Sl_DBus}, 128'h0);
    check("tied_outs", {125'h0, bus.Sl_errAck,
          bus.Sl_retry, bus.Sl_toutSup}, 128'h0);

    xfer(HIGH + 32'd4, 1'b1, 4'hF, 32'h0);
    check("miss_ack", {127'h0, ack_seen}, 128'h0);
    check("miss_dbus", {96'h0, dbus_or}, 128'h0);

    xfer(BASE + 32'h40, 1'b1, 4'hF, 32'h0);
    check("oor_rd_ack", {127'h0, ack_seen}, 128'h1);
    check("oor_rd_val", {96'h0, rd_val}, 128'h0);

`ifndef OPB_REG_BANK_SHADOW_EN
    xfer(BASE + 32'h8, 1'b0, 4'hF, 32'hDEADBEEF);
    check("wr2_ack", {127'h0, ack_seen}, 128'h1);
    check("wr2_stb", {124'h0, stb_at}, 128'h4);
    check("wr2_udo", udo_at[95:64], 128'hDEADBEEF);
    check("wr2_ack_off", {127'h0, post_ack}, 128'h0);
    check("wr2_stb_off", {124'h0, post_stb}, 128'h0);

    xfer(BASE + 32'h8, 1'b1, 4'hF, 32'h0);
    check("rd2_val", {96'h0, rd_val}, 128'hDEADBEEF);
    check("rd2_stb", {124'h0, stb_at}, 128'h0);

    xfer(BASE, 1'b0, 4'hF, 32'h11223344);
    xfer(BASE, 1'b0, 4'b0011, 32'h0000ABCD);
    check("be_stb", {124'h0, stb_at}, 128'h1);
    check("be_udo0", udo[31:0], 128'h1122ABCD);

    xfer(BASE, 1'b0, 4'b0000, 32'hFFFFFFFF);
    check("be0_stb", {124'h0, stb_at}, 128'h1);
    check("be0_udo0", udo[31:0], 128'h1122ABCD);

    xfer(BASE + 32'h40, 1'b0, 4'hF, 32'h99999999);
    check("oor_wr_ack", {127'h0, ack_seen}, 128'h1);
    check("oor_wr_stb", {124'h0, stb_at}, 128'h0);
    check("oor_wr_udo", udo,
          {32'h0, 32'hDEADBEEF, 32'h0, 32'h1122ABCD});

    bus.OPB_ABus   = BASE + 32'h4;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_BE     = 4'hF;
    bus.OPB_DBus   = 32'h00000055;
    bus.OPB_select = 1'b1;
    acks = 0;
    strobes = 0;
    ack_cyc = 0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) bus.OPB_select = 1'b0;
      if (bus.Sl_xferAck) begin
        acks++;
        ack_cyc = c;
      end
      if (stb[1]) strobes++;
    end
    tick();
    check("held_acks", 128'(acks), 128'd1);
    check("held_ack_cyc", 128'(ack_cyc), 128'd2);
    check("held_stbs", 128'(strobes), 128'd1);
    check("held_udo1", udo[63:32], 128'h55);
`else
    xfer(BASE, 1'b0, 4'hF, 32'h0000000A);
    check("sh_wr0_stb", {124'h0, stb_at}, 128'h0);
    xfer(BASE + 32'hC, 1'b0, 4'hF, 32'h0000000B);
    check("sh_wr3_stb", {124'h0, stb_at}, 128'h0);
    check("sh_udo_hold", udo, 128'h0);

    xfer(BASE, 1'b1, 4'hF, 32'h0);
    check("sh_rd0", {96'h0, rd_val}, 128'hA);
    xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h0);
    check("sh_pend", {96'h0, rd_val}, 128'h9);

    xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h0);
    check("sh_nocommit", udo, 128'h0);

    xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h1);
    check("sh_cm_ack", {127'h0, ack_seen}, 128'h1);
    check("sh_cm_stb", {124'h0, stb_at}, 128'h9);
    check("sh_cm_udo", udo_at,
          {32'hB, 32'h0, 32'h0, 32'hA});
    check("sh_cm_stb_off", {124'h0, post_stb}, 128'h0);

    xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h0);
    check("sh_pend_clr", {96'h0, rd_val}, 128'h0);
`endif

    bus.OPB_ABus   = BASE + 32'h8;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_BE     = 4'hF;
    bus.OPB_DBus   = 32'hFFFFFFFF;
    bus.OPB_select = 1'b1;
    rst = 1'b1;
    tick();
    check("rstx_ack", {127'h0, bus.Sl_xferAck}, 128'h0);
    check("rstx_udo", udo, 128'h0);
    check("rstx_stb", {124'h0, stb}, 128'h0);
    rst = 1'b0;
    bus.OPB_select = 1'b0;
    tick();
    check("rstx_ack2", {127'h0, bus.Sl_xferAck}, 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
